ula_seq: RTL and testbench

- Clocked, parametrised successor to the combinational ALU used in the datapath.
- Keeps the 4-bit opcode map for ops 0–11.
- Adds a start/busy/done handshake, iterative multi-cycle multiply and divide with high-word/remainder output, and status flags.
- Replaces x-outputs with defined results and error flags.
- Sits between the register file and the writeback mux; the control FSM stalls on busy.

---
 rtl/ula_seq.sv | 216 +++++++++++++++++++++
 tb/tb_ula_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// Clocked unsigned ALU with a start/busy/done handshake.
// Most ops resolve on the accept edge; multiply and divide iterate one bit per clock.
module ula_seq #(
    parameter int NBITS = 16,
    parameter int CNTW  = $clog2(NBITS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [NBITS-1:0] opnd1,
    input  logic [NBITS-1:0] opnd2,
    output logic [NBITS-1:0] out,
    output logic [NBITS-1:0] hi,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry,
    output logic             dbz,
    output logic             err
);

    typedef enum logic [3:0] {
        OP_A   = 4'd0,
        OP_B   = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_MUL = 4'd4,
        OP_DIV = 4'd5,
        OP_EQ  = 4'd6,
        OP_GT  = 4'd7,
        OP_LT  = 4'd8,
        OP_SHR = 4'd9,
        OP_AND = 4'd10,
        OP_OR  = 4'd11,
        OP_SHL = 4'd12,
        OP_XOR = 4'd13
    } op_t;

    typedef enum logic {
        S_IDLE,
        S_CALC
    } state_t;

    localparam logic [NBITS-1:0] L_NB   = NBITS'(NBITS);
    localparam logic [CNTW-1:0]  L_LAST = CNTW'(NBITS - 1);

    state_t            r_state;
    logic [CNTW-1:0]   r_cnt;
    logic              r_is_div;
    logic [NBITS-1:0]  r_opnd;
    logic [NBITS-1:0]  r_acc_hi;
    logic [NBITS-1:0]  r_acc_lo;

    logic [NBITS-1:0]  r_out;
    logic [NBITS-1:0]  r_hi;
    logic              r_busy;
    logic              r_done;
    logic              r_zero;
    logic              r_carry;
    logic              r_dbz;
    logic              r_err;

    op_t               w_op;
    logic [NBITS:0]    w_add;
    logic [NBITS:0]    w_sub;
    logic [NBITS-1:0]  w_res;
    logic [NBITS-1:0]  w_hi;
    logic              w_carry;
    logic              w_dbz;
    logic              w_err;
    logic              w_multi;

    logic [NBITS:0]    w_mul_sum;
    logic [NBITS:0]    w_div_trial;
    logic              w_div_ge;
    logic [NBITS-1:0]  w_div_diff;
    logic [NBITS-1:0]  w_nxt_hi;
    logic [NBITS-1:0]  w_nxt_lo;

    assign w_op  = op_t'(op);
    assign w_add = {1'b0, opnd1} + {1'b0, opnd2};
    assign w_sub = {1'b0, opnd1} - {1'b0, opnd2};

    // Single-cycle result path, evaluated against the live operand ports.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        w_res   = '0;
        w_hi    = '0;
        w_carry = 1'b0;
        w_dbz   = 1'b0;
        w_err   = 1'b0;
        w_multi = 1'b0;
        case (w_op)
            OP_A:   w_res = opnd1;
            OP_B:   w_res = opnd2;
            OP_ADD: begin
                w_res   = w_add[NBITS-1:0];
                w_carry = w_add[NBITS];
            end
            OP_SUB: begin
                w_res   = w_sub[NBITS-1:0];
                w_carry = w_sub[NBITS];
            end
            OP_MUL: w_multi = 1'b1;
            OP_DIV: begin
                if (opnd2 == '0) begin
                    w_res = '1;
                    w_hi  = opnd1;
                    w_dbz = 1'b1;
                end else begin
                    w_multi = 1'b1;
                end
            end
            OP_EQ:  w_res = {{(NBITS-1){1'b0}}, opnd1 == opnd2};
            OP_GT:  w_res = {{(NBITS-1){1'b0}}, opnd1 > opnd2};
            OP_LT:  w_res = {{(NBITS-1){1'b0}}, opnd1 < opnd2};
            OP_SHR: w_res = (opnd2 >= L_NB) ? '0 : (opnd1 >> opnd2);
            OP_AND: w_res = opnd1 & opnd2;
            OP_OR:  w_res = opnd1 | opnd2;
            OP_SHL: w_res = (opnd2 >= L_NB) ? '0 : (opnd1 << opnd2);
            OP_XOR: w_res = opnd1 ^ opnd2;
            default: w_err = 1'b1;
        endcase
    end

    // One iteration step; the accumulator pair holds {high, low} product or {remainder, dividend/quotient}.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
        w_div_trial = {r_acc_hi, r_acc_lo[NBITS-1]};
        w_div_ge    = (w_div_trial >= {1'b0, r_opnd});
        w_div_diff  = w_div_trial[NBITS-1:0] - r_opnd;
        if (r_is_div) begin
            w_nxt_hi = w_div_ge ? w_div_diff : w_div_trial[NBITS-1:0];
            w_nxt_lo = {r_acc_lo[NBITS-2:0], w_div_ge};
        end else begin
            w_nxt_hi = w_mul_sum[NBITS:1];
            w_nxt_lo = {w_mul_sum[0], r_acc_lo[NBITS-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_opnd   <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_out    <= '0;
            r_hi     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_dbz    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_multi) begin
                            r_state  <= S_CALC;
                            r_busy   <= 1'b1;
                            r_cnt    <= '0;
                            r_is_div <= (w_op == OP_DIV);
                            r_opnd   <= (w_op == OP_DIV) ? opnd2 : opnd1;
                            r_acc_hi <= '0;
                            r_acc_lo <= (w_op == OP_DIV) ? opnd1 : opnd2;
                        end else begin
                            r_out   <= w_res;
                            r_hi    <= w_hi;
                            r_zero  <= (w_res == '0);
                            r_carry <= w_carry;
                            r_dbz   <= w_dbz;
                            r_err   <= w_err;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_acc_hi <= w_nxt_hi;
                    r_acc_lo <= w_nxt_lo;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == L_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_out   <= w_nxt_lo;
                        r_hi    <= w_nxt_hi;
                        r_zero  <= (w_nxt_lo == '0);
                        r_carry <= 1'b0;
                        r_dbz   <= 1'b0;
                        r_err   <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out   = r_out;
    assign hi    = r_hi;
    assign busy  = r_busy;
    assign done  = r_done;
    assign zero  = r_zero;
    assign carry = r_carry;
    assign dbz   = r_dbz;
    assign err   = r_err;

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq (NBITS=16): stimulus pushes hand-computed results,
// a negedge monitor pops and compares them whenever done is seen.
module tb_ula_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [15:0] opnd1;
    logic [15:0] opnd2;
    logic [15:0] out;
    logic [15:0] hi;
    logic        busy;
    logic        done;
    logic        zero;
    logic        carry;
    logic        dbz;
    logic        err;

    typedef struct {
        logic [15:0] out;
        logic [15:0] hi;
        logic        zero;
        logic        carry;
        logic        dbz;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_pass;

    ula_seq #(.NBITS(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .opnd1 (opnd1),
        .opnd2 (opnd2),
        .out   (out),
        .hi    (hi),
        .busy  (busy),
        .done  (done),
        .zero  (zero),
        .carry (carry),
        .dbz   (dbz),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation, on the expected cycle.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("out",   out,   e.out);
                check("hi",    hi,    e.hi);
                check("zero",  zero,  e.zero);
                check("carry", carry, e.carry);
                check("dbz",   dbz,   e.dbz);
                check("err",   err,   e.err);
            end
        end
    end

    // n = clock edges after the accept edge before done is registered (0 for single-cycle ops).
    task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b, input int n,
                         input logic [15:0] eo, input logic [15:0] eh,
                         input logic ez, input logic ec, input logic ed, input logic ee);
        exp_t e;
        @(negedge clk);
        op    = o;
        opnd1 = a;
        opnd2 = b;
        start = 1'b1;
        e.out   = eo;
        e.hi    = eh;
        e.zero  = ez;
        e.carry = ec;
        e.dbz   = ed;
        e.err   = ee;
        e.cyc   = cyc + 1 + n;
        sb.push_back(e);
    endtask

    // Deassert start and scramble operands to show they are not re-sampled.
    task automatic idle();
        @(negedge clk);
        start = 1'b0;
        op    = 4'd2;
        opnd1 = 16'hA5A5;
        opnd2 = 16'h5A5A;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("drain_pending", sb.size(), 0);
    endtask

    initial begin
        int busy_cnt;
        n_checks = 0;
        n_pass   = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        opnd1 = 16'h0;
        opnd2 = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_out",  out,  16'h0);
        check("rst_hi",   hi,   16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_flags", {zero, carry, dbz, err}, 4'b0000);
        rst = 1'b0;

        // Add overflow: wraps to 0 with carry.
        issue(4'd2, 16'hFFFF, 16'h0001, 0, 16'h0000, 16'h0000, 1, 1, 0, 0);
        idle();
        check("add_busy", busy, 1'b0);
        drain();

        // Multiply: busy for exactly 16 cycles, done after the 16th iteration edge.
        issue(4'd4, 16'd300, 16'd300, 16, 16'h5F90, 16'h0001, 0, 0, 0, 0);
        idle();
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        check("mul_busy_cycles", busy_cnt, 16);
        drain();

        // Divide, then divide by zero resolved on the accept edge.
        issue(4'd5, 16'd1000, 16'd7, 16, 16'd142, 16'd6, 0, 0, 0, 0);
        idle();
        drain();
        issue(4'd5, 16'd5, 16'd0, 0, 16'hFFFF, 16'd5, 0, 0, 1, 0);
        idle();
        check("dbz_busy", busy, 1'b0);
        drain();

        // A start pulse at E3 while busy is ignored; only the multiply completes.
        issue(4'd4, 16'd3, 16'd5, 16, 16'd15, 16'd0, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        @(negedge clk);
        op    = 4'd2;
        opnd1 = 16'd1;
        opnd2 = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset mid-multiply aborts the operation with no done.
        issue(4'd4, 16'd3, 16'd5, 16, 16'd15, 16'd0, 0, 0, 0, 0);
        idle();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_out",  out,  16'h0);
        check("abort_hi",   hi,   16'h0);
        check("abort_busy", busy, 1'b0);
        check("abort_flags", {zero, carry, dbz, err}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_abort_busy", busy, 1'b0);

        // Subtract with borrow.
        issue(4'd3, 16'd2, 16'd3, 0, 16'hFFFF, 16'h0, 0, 1, 0, 0);
        idle();
        drain();

        // Shifts, shift boundary, illegal op and err clearing, back to back.
        issue(4'd9,  16'h8000, 16'd20,    0, 16'h0000, 16'h0, 1, 0, 0, 0);
        issue(4'd12, 16'h0001, 16'd15,    0, 16'h8000, 16'h0, 0, 0, 0, 0);
        issue(4'd12, 16'h0001, 16'd16,    0, 16'h0000, 16'h0, 1, 0, 0, 0);
        issue(4'd9,  16'h8000, 16'd15,    0, 16'h0001, 16'h0, 0, 0, 0, 0);
        issue(4'd14, 16'h1234, 16'h5678,  0, 16'h0000, 16'h0, 1, 0, 0, 1);
        issue(4'd13, 16'h00FF, 16'h0F0F,  0, 16'h0FF0, 16'h0, 0, 0, 0, 0);
        idle();
        drain();

        // Compares on consecutive cycles.
        issue(4'd6, 16'd4, 16'd4, 0, 16'd1, 16'h0, 0, 0, 0, 0);
        issue(4'd7, 16'd4, 16'd4, 0, 16'd0, 16'h0, 1, 0, 0, 0);
        issue(4'd8, 16'd4, 16'd4, 0, 16'd0, 16'h0, 1, 0, 0, 0);
        idle();
        drain();

        // Logic ops and pass-through.
        issue(4'd10, 16'hF0F0, 16'h3C3C, 0, 16'h3030, 16'h0, 0, 0, 0, 0);
        issue(4'd11, 16'hF000, 16'h000F, 0, 16'hF00F, 16'h0, 0, 0, 0, 0);
        issue(4'd1,  16'h1111, 16'hBEEF, 0, 16'hBEEF, 16'h0, 0, 0, 0, 0);
        issue(4'd15, 16'h0001, 16'h0001, 0, 16'h0000, 16'h0, 1, 0, 0, 1);
        issue(4'd0,  16'hCAFE, 16'h0000, 0, 16'hCAFE, 16'h0, 0, 0, 0, 0);
        idle();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
